regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Owns the single write port of `register_file`.
- After reset it sequences a clear pass that zeroes x1..x31, because the register file has no reset of its own.
- It then shares the write port between two writeback requesters with round-robin arbitration: port A (ALU writeback) and port B (load/store writeback).
- Sits between the execute/memory stages and the register file.

Parameters:
- ADDR_W, 5, register address width.
- DATA_W, 32, register data width.
- NUM_REGS, 32, number of architectural registers; the clear pass covers indices 1..NUM_REGS-1.
- CLEAR_ON_RESET, 1, 1 = run the clear pass after reset; 0 = enter RUN directly.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- a_valid  input  1  requester A has a write pending.
- a_ready  output  1  requester A's write is accepted this cycle.
- a_addr  input  ADDR_W  requester A destination register.
- a_data  input  DATA_W  requester A write data.
- b_valid  input  1  requester B has a write pending.
- b_ready  output  1  requester B's write is accepted this cycle.
- b_addr  input  ADDR_W  requester B destination register.
- b_data  input  DATA_W  requester B write data.
- rf_rd_addr  output  ADDR_W  to `register_file.rd_addr`.
- rf_rd_data  output  DATA_W  to `register_file.rd_data`.
- rf_we  output  1  to `register_file.reg_write_enable`.
- init_done  output  1  high once the clear pass is complete (held high in RUN).

Behaviour:
- Clock and reset:
  - One clock, clk.
  - Reset rst is synchronous and active-high.
- Registered state:
  - state: CLEAR or RUN.
  - clr_idx: ADDR_W bits.
  - rr_ptr: 1 bit; 0 = A has priority, 1 = B has priority.
- Reset values:
  - state = CLEAR if CLEAR_ON_RESET, else RUN.
  - clr_idx = 1.
  - rr_ptr = 0.
- Outputs are combinational from state plus inputs. While rst is high they are forced to:
  - rf_we = 0, a_ready = 0, b_ready = 0.
  - rf_rd_addr = 0, rf_rd_data = 0.
  - init_done = 0 (except CLEAR_ON_RESET = 0, where init_done = 1 once rst deasserts).
- CLEAR state:
  - rf_we = 1, rf_rd_addr = clr_idx, rf_rd_data = 0.
  - a_ready = b_ready = 0; init_done = 0.
  - clr_idx increments each cycle.
  - When clr_idx == NUM_REGS-1, the next state is RUN.
  - Exactly NUM_REGS-1 cycles; 31 with defaults.
- RUN state:
  - init_done = 1.
  - Grant selection:
    - Only one valid: that requester is granted.
    - Both valid: the requester selected by rr_ptr is granted.
    - Neither valid: no grant, rf_we = 0, rr_ptr unchanged.
  - Granted requester: ready = 1 in the same cycle. The other requester's ready = 0.
  - Write path: rf_rd_addr and rf_rd_data mux from the granted requester.
  - Latency: the write lands at the posedge ending the handshake cycle. Zero added latency.
  - rr_ptr update: after any grant, rr_ptr points to the non-granted requester. Consequently, alternation under continuous contention is A, B, A, B...
  - Writes to x0 (addr == 0): handshake completes (ready = 1), rf_we = 0, and the request is consumed without a write. It still counts as a grant for rr_ptr.
  - Ready is independent of addr. The requester must hold valid, addr and data stable until ready.
- Same-address contention: no merging. Writes are serialized in grant order; the last one granted wins.
- rst asserted mid-CLEAR or mid-RUN:
  - All state returns to reset values and the clear pass restarts.
  - Any in-flight request simply sees ready = 0.
- No combinational path from a_ready/b_ready back into any valid.

Decomposition:
- Shared package rf_pkg holds:
  - REG_ADDR_W = 5, REG_DATA_W = 32, NUM_REGS = 32.
  - typedef reg_addr_t, typedef reg_data_t.
  - enum wb_state_t {CLEAR, RUN}.
- One natural sub-module: rr_arb2, a 2-requester round-robin arbiter with rr_ptr, req[1:0] and grant[1:0].
- Clear sequencing and the write-port mux stay in the top.

Test Plan:
- Reset then idle, CLEAR_ON_RESET = 1 → expected:
  - rf_we = 1 for exactly 31 cycles with rf_rd_addr 1..31 and rf_rd_data = 0.
  - init_done rises on cycle 32.
  - Readies are 0 throughout the clear pass.
- RUN, A-only request (a_addr = 5, a_data = 0xDEADBEEF) → a_ready = 1 the same cycle, rf_we = 1, addr 5, data 0xDEADBEEF; register x5 reads 0xDEADBEEF next cycle.
- RUN, A and B both valid for 4 cycles with distinct addresses 3 and 7 → grants alternate A, B, A, B; each ready is high only on its granted cycles.
- RUN, B writes addr 0, data 0x1234 → b_ready = 1, rf_we = 0; x0 still reads 0.
- Both valid with the same addr 9 (A data 0x11, B data 0x22), rr_ptr = 0 → A written first, then B; x9 ends at 0x22.
- rst pulsed during clear at clr_idx = 10 → clr_idx restarts at 1 and a full 31-cycle clear follows; init_done stays 0 until it completes.

Source files
------------

// File: rtl/rf_pkg.sv
// ============================================================================
// Module      : rf_pkg
// Description : Shared register-file widths, types and writeback FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package rf_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int NUM_REGS   = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_DATA_W-1:0] reg_data_t;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } wb_state_t;

endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
// ============================================================================
// Module      : rr_arb2
// Description : Two-requester round-robin arbiter; pointer moves past winner.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_en,
  input  logic [1:0] i_req,
  output logic [1:0] o_grant
);

  logic       r_rr_ptr;
  logic [1:0] w_grant;

  // r_rr_ptr = 0 favours requester 0, 1 favours requester 1.
  always_comb begin
    w_grant    = 2'b00;
    w_grant[0] = i_req[0] & (~i_req[1] | ~r_rr_ptr);
    w_grant[1] = i_req[1] & (~i_req[0] |  r_rr_ptr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= 1'b0;
    end else if (i_en && (w_grant != 2'b00)) begin
      r_rr_ptr <= w_grant[0];
    end
  end

  assign o_grant = w_grant;

endmodule

`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
// ============================================================================
// Module      : regfile_wb_arbiter
// Description : Owns the register-file write port: post-reset clear pass,
//               then round-robin sharing between ALU and load/store writeback.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module regfile_wb_arbiter #(
  parameter int ADDR_W         = rf_pkg::REG_ADDR_W,
  parameter int DATA_W         = rf_pkg::REG_DATA_W,
  parameter int NUM_REGS       = rf_pkg::NUM_REGS,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic [ADDR_W-1:0] rf_rd_addr,
  output logic [DATA_W-1:0] rf_rd_data,
  output logic              rf_we,
  output logic              init_done
);

  localparam logic [ADDR_W-1:0] c_LAST_IDX  = ADDR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W-1:0] c_FIRST_IDX = ADDR_W'(1);
  localparam rf_pkg::wb_state_t c_RESET_STATE =
    CLEAR_ON_RESET ? rf_pkg::CLEAR : rf_pkg::RUN;

  rf_pkg::wb_state_t r_state;
  rf_pkg::wb_state_t w_state_next;
  logic [ADDR_W-1:0] r_clr_idx;
  logic [1:0]        w_grant;
  logic              w_arb_en;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_data;

  assign w_arb_en = (r_state == rf_pkg::RUN) && !rst;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .i_en    (w_arb_en),
    .i_req   ({b_valid, a_valid}),
    .o_grant (w_grant)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= c_RESET_STATE;
      r_clr_idx <= c_FIRST_IDX;
    end else begin
      r_state <= w_state_next;
      if (r_state == rf_pkg::CLEAR) begin
        r_clr_idx <= r_clr_idx + 1'b1;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    if ((r_state == rf_pkg::CLEAR) && (r_clr_idx == c_LAST_IDX)) begin
      w_state_next = rf_pkg::RUN;
    end
  end

  always_comb begin
    w_sel_addr = '0;
    w_sel_data = '0;
    if (w_grant[0]) begin
      w_sel_addr = a_addr;
      w_sel_data = a_data;
    end else if (w_grant[1]) begin
      w_sel_addr = b_addr;
      w_sel_data = b_data;
    end
  end

  // A grant to x0 still handshakes; only the write strobe is suppressed.
  always_comb begin
    a_ready    = 1'b0;
    b_ready    = 1'b0;
    rf_we      = 1'b0;
    rf_rd_addr = '0;
    rf_rd_data = '0;
    init_done  = 1'b0;
    if (!rst) begin
      unique case (r_state)
        rf_pkg::CLEAR: begin
          rf_we      = 1'b1;
          rf_rd_addr = r_clr_idx;
        end
        rf_pkg::RUN: begin
          init_done  = 1'b1;
          a_ready    = w_grant[0];
          b_ready    = w_grant[1];
          rf_rd_addr = w_sel_addr;
          rf_rd_data = w_sel_data;
          rf_we      = (w_grant != 2'b00) && (w_sel_addr != '0);
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
// ============================================================================
// Module      : tb_regfile_wb_arbiter
// Description : Directed + random bench with a behavioural writeback model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_regfile_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        a_valid, b_valid;
  logic        a_ready, b_ready;
  logic [4:0]  a_addr, b_addr;
  logic [31:0] a_data, b_data;
  logic [4:0]  rf_rd_addr;
  logic [31:0] rf_rd_data;
  logic        rf_we;
  logic        init_done;

  regfile_wb_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .a_valid    (a_valid),
    .a_ready    (a_ready),
    .a_addr     (a_addr),
    .a_data     (a_data),
    .b_valid    (b_valid),
    .b_ready    (b_ready),
    .b_addr     (b_addr),
    .b_data     (b_data),
    .rf_rd_addr (rf_rd_addr),
    .rf_rd_data (rf_rd_data),
    .rf_we      (rf_we),
    .init_done  (init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: clear countdown, "who goes first on a tie", and a
  // shadow register array; tb_rf is the register file the DUT actually drives.
  int          m_clear_left = 0;
  bit          m_b_first    = 1'b0;
  bit          last_ga      = 1'b0;
  bit          last_gb      = 1'b0;
  bit          seeded       = 1'b0;
  logic [31:0] m_rf  [32];
  logic [31:0] tb_rf [32];
  bit          e_ga, e_gb, e_we, e_init;
  logic [4:0]  e_addr;
  logic [31:0] e_data;

  always @(negedge clk) begin
    e_ga = 1'b0; e_gb = 1'b0; e_we = 1'b0; e_addr = '0; e_data = '0;
    e_init = 1'b0;
    if (!rst) begin
      if (m_clear_left > 0) begin
        e_we   = 1'b1;
        e_addr = 5'(32 - m_clear_left);
      end else begin
        e_init = 1'b1;
        e_ga   = a_valid && (!b_valid || !m_b_first);
        e_gb   = b_valid && !e_ga;
        if (e_ga) begin
          e_addr = a_addr; e_data = a_data;
        end else if (e_gb) begin
          e_addr = b_addr; e_data = b_data;
        end
        e_we = (e_ga || e_gb) && (e_addr != 5'd0);
      end
    end
    chk("a_ready",   32'(a_ready),   32'(e_ga));
    chk("b_ready",   32'(b_ready),   32'(e_gb));
    chk("rf_we",     32'(rf_we),     32'(e_we));
    chk("init_done", 32'(init_done), 32'(e_init));
    if (e_we || e_ga || e_gb) chk("wr_addr", 32'(rf_rd_addr), 32'(e_addr));
    if (e_we)                 chk("wr_data", rf_rd_data, e_data);
  end

  always @(posedge clk) begin
    if (!seeded) begin
      for (int i = 0; i < 32; i++) begin
        m_rf[i]  <= (i == 0) ? 32'd0 : (32'hBAD0_0000 | 32'(i));
        tb_rf[i] <= (i == 0) ? 32'd0 : (32'hBAD0_0000 | 32'(i));
      end
      seeded <= 1'b1;
    end else if (rf_we === 1'b1) begin
      tb_rf[rf_rd_addr] <= rf_rd_data;
    end
    if (rst) begin
      m_clear_left <= 31;
      m_b_first    <= 1'b0;
      last_ga      <= 1'b0;
      last_gb      <= 1'b0;
    end else if (m_clear_left > 0) begin
      if (seeded) m_rf[e_addr] <= 32'd0;
      m_clear_left <= m_clear_left - 1;
      last_ga      <= 1'b0;
      last_gb      <= 1'b0;
    end else begin
      if (e_ga)      m_b_first <= 1'b1;
      else if (e_gb) m_b_first <= 1'b0;
      if (e_we) m_rf[e_addr] <= e_data;
      last_ga <= e_ga;
      last_gb <= e_gb;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Expects rst to have just been released; walks the full clear pass.
  task automatic check_clear(input string tag);
    for (int i = 1; i <= 31; i++) begin
      @(negedge clk);
      chk({tag, "_we"},    32'(rf_we),             32'd1);
      chk({tag, "_addr"},  32'(rf_rd_addr),        32'(i));
      chk({tag, "_data"},  rf_rd_data,             32'd0);
      chk({tag, "_rdy"},   32'(a_ready | b_ready), 32'd0);
      chk({tag, "_ninit"}, 32'(init_done),         32'd0);
    end
    @(negedge clk);
    chk({tag, "_init"},    32'(init_done), 32'd1);
    chk({tag, "_idle_we"}, 32'(rf_we),     32'd0);
  endtask

  initial begin
    int nz;
    rst = 1'b1;
    a_valid = 1'b0; a_addr = '0; a_data = '0;
    b_valid = 1'b0; b_addr = '0; b_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_we",    32'(rf_we),     32'd0);
    chk("rst_init",  32'(init_done), 32'd0);
    chk("rst_addr",  32'(rf_rd_addr), 32'd0);
    cyc();
    rst = 1'b0;
    check_clear("clr1");
    nz = 0;
    for (int i = 1; i < 32; i++) if (tb_rf[i] !== 32'd0) nz++;
    chk("clear_zeroed", 32'(nz), 32'd0);

    // Continuous contention: A, B, A, B.
    cyc();
    a_valid = 1'b1; a_addr = 5'd3; a_data = 32'hAAAA_0003;
    b_valid = 1'b1; b_addr = 5'd7; b_data = 32'hBBBB_0007;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("alt_a_ready", 32'(a_ready),    32'((k % 2) == 0));
      chk("alt_b_ready", 32'(b_ready),    32'((k % 2) == 1));
      chk("alt_addr",    32'(rf_rd_addr), ((k % 2) == 0) ? 32'd3 : 32'd7);
      cyc();
    end
    a_valid = 1'b0; b_valid = 1'b0;

    cyc();
    a_valid = 1'b1; a_addr = 5'd5; a_data = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("x5_ready", 32'(a_ready),    32'd1);
    chk("x5_we",    32'(rf_we),      32'd1);
    chk("x5_addr",  32'(rf_rd_addr), 32'd5);
    chk("x5_data",  rf_rd_data,      32'hDEAD_BEEF);
    cyc();
    a_valid = 1'b0;
    chk("x5_read", tb_rf[5], 32'hDEAD_BEEF);

    b_valid = 1'b1; b_addr = 5'd0; b_data = 32'h0000_1234;
    @(negedge clk);
    chk("x0_ready", 32'(b_ready), 32'd1);
    chk("x0_we",    32'(rf_we),   32'd0);
    cyc();
    b_valid = 1'b0;
    chk("x0_read", tb_rf[0], 32'd0);

    a_valid = 1'b1; a_addr = 5'd9; a_data = 32'h11;
    b_valid = 1'b1; b_addr = 5'd9; b_data = 32'h22;
    @(negedge clk);
    chk("x9_first_a", 32'(a_ready), 32'd1);
    chk("x9_first_d", rf_rd_data,   32'h11);
    cyc();
    a_valid = 1'b0;
    @(negedge clk);
    chk("x9_then_b",  32'(b_ready), 32'd1);
    chk("x9_then_d",  rf_rd_data,   32'h22);
    cyc();
    b_valid = 1'b0;
    chk("x9_final", tb_rf[9], 32'h22);

    // Reset pulse in the middle of a clear pass (clr_idx = 10).
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    repeat (9) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("midclr_rst_we", 32'(rf_we), 32'd0);
    cyc();
    rst = 1'b0;
    check_clear("clr2");

    // Random traffic with hold-until-ready and occasional resets.
    for (int n = 0; n < 600; n++) begin
      cyc();
      rst = ($urandom_range(0, 199) == 0);
      if (!a_valid || last_ga) begin
        a_valid = 1'($urandom_range(0, 1));
        a_addr  = 5'($urandom);
        a_data  = 32'($urandom);
      end
      if (!b_valid || last_gb) begin
        b_valid = 1'($urandom_range(0, 1));
        b_addr  = 5'($urandom);
        b_data  = 32'($urandom);
      end
    end
    cyc();
    rst = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
    repeat (40) cyc();
    for (int i = 0; i < 32; i++) chk("final_rf", tb_rf[i], m_rf[i]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
